data_mem_rv32i: RTL and testbench

Data-memory responder for the RV32I datapath. It accepts load/store requests carrying the ALU-computed address, the store data, `wr_mem` and the byte-store select. It performs word or byte-lane writes into an internal word-addressed array, returns registered read data on `dataout_mem`, and signals completion with a one-cycle `mem_done` pulse. The controller uses that pulse to release the PC stall.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 39 +++
 rtl/data_mem_rv32i.sv | 134 +++++++++++++
 tb/tb_data_mem_rv32i.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the RV32I data memory: FSM states, MMIO address, lane width, fault causes.
// Pure declarations; no timing or flow-control behaviour of its own.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_RANGE    = 2'd1,
    FAULT_MISALIGN = 2'd2
  } fault_t;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
  localparam int          BYTE_W    = 8;
  localparam int          LANES     = 4;

  // Byte stores touch one lane, word stores all four.
  function automatic logic [LANES-1:0] lane_mask(input logic byte_sel, input logic [1:0] lane);
    lane_mask = byte_sel ? (4'b0001 << lane) : 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 RAM with byte write enables and a registered read port; contents never reset.
// Read data appears one edge after rd_en and is held otherwise; no backpressure.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic          ovr_vld,
  input  logic [31:0]   ovr_dat,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // The override lets the owner load a non-array value (zero on fault, MMIO) into the read register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (ovr_vld) begin
      rd_data <= ovr_dat;
    end else if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_rv32i.sv
// RV32I data memory responder: 2-cycle request-to-done, req ignored during ACCESS, no queueing.
// Optional memory-mapped output register at MMIO_ADDR when DMEM_MMIO_EN is defined.
module data_mem_rv32i
  import dmem_pkg::*;
#(
  parameter int N           = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         wr_mem,
  input  logic         store_sel,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] datain_mem,
  output logic [N-1:0] dataout_mem,
  output logic         mem_done,
  output logic         mem_err,
  output logic [N-1:0] mmio_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [N-1:0]     addr_q, data_q;
  logic             wr_q, bsel_q;
  logic             capture, in_access, is_mmio;
  fault_t           fault;
  logic [LANES-1:0] mask, wr_en;
  logic             rd_en, ovr_vld;
  logic [N-1:0]     wdata, ovr_dat, mmio_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = req ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign capture   = req && ((state_q == IDLE) || (state_q == RESP));
  assign in_access = (state_q == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      bsel_q <= 1'b0;
    end else if (capture) begin
      addr_q <= addr;
      data_q <= datain_mem;
      wr_q   <= wr_mem;
      bsel_q <= store_sel;
    end
  end

`ifdef DMEM_MMIO_EN
  assign is_mmio = (addr_q[N-1:2] == MMIO_ADDR[N-1:2]);
`else
  assign is_mmio = 1'b0;
`endif

  // Out-of-range dominates; misalignment only matters for word stores.
  always_comb begin
    fault = FAULT_NONE;
    if ((|addr_q[N-1:AW+2]) && !is_mmio) begin
      fault = FAULT_RANGE;
    end else if (wr_q && !bsel_q && (addr_q[1:0] != 2'b00)) begin
      fault = FAULT_MISALIGN;
    end
  end

  assign mask    = lane_mask(bsel_q, addr_q[1:0]);
  assign wdata   = bsel_q ? {LANES{data_q[BYTE_W-1:0]}} : data_q;
  assign wr_en   = (in_access && wr_q && !is_mmio && (fault == FAULT_NONE)) ? mask : '0;
  assign rd_en   = in_access && !wr_q;
  assign ovr_vld = rd_en && ((fault != FAULT_NONE) || is_mmio);
  assign ovr_dat = is_mmio ? mmio_q : '0;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .idx    (addr_q[AW+1:2]),
    .wdata  (wdata),
    .ovr_vld(ovr_vld),
    .ovr_dat(ovr_dat),
    .rd_data(dataout_mem)
  );

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mmio_q <= '0;
    end else if (in_access && wr_q && is_mmio && (fault == FAULT_NONE)) begin
      for (int i = 0; i < LANES; i++) begin
        if (mask[i]) begin
          mmio_q[i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end
`else
  assign mmio_q = '0;
`endif

  assign mmio_out = mmio_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      mem_done <= in_access;
      mem_err  <= in_access && (fault != FAULT_NONE);
    end
  end

endmodule

// File: tb/tb_data_mem_rv32i.sv
// Directed bench for data_mem_rv32i with a queue scoreboard of expected responses.
module tb_data_mem_rv32i;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wr_mem = 1'b0;
  logic        store_sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] datain_mem = '0;
  logic [31:0] dataout_mem;
  logic        mem_done;
  logic        mem_err;
  logic [31:0] mmio_out;

  data_mem_rv32i #(.N(32), .DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wr_mem     (wr_mem),
    .store_sel  (store_sel),
    .addr       (addr),
    .datain_mem (datain_mem),
    .dataout_mem(dataout_mem),
    .mem_done   (mem_done),
    .mem_err    (mem_err),
    .mmio_out   (mmio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_dat = '0;
  logic [31:0] b2b_val [4];
  logic        mmio_exp_err;
  logic [31:0] mmio_exp_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated request; stores must leave dataout_mem at the last loaded value.
  task automatic access(input string tag, input logic wr, input logic bsel, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_dat);
    exp_t x;
    int   lat;
    x.dat = wr ? last_dat : exp_dat;
    x.err = exp_err;
    last_dat = x.dat;
    sb_q.push_back(x);
    @(posedge clk); #1;
    req = 1'b1; wr_mem = wr; store_sel = bsel; addr = a; datain_mem = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!mem_done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    x = sb_q.pop_front();
    check({tag, "_err"}, {31'd0, mem_err}, {31'd0, x.err});
    check({tag, "_data"}, dataout_mem, x.dat);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, mem_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b2b_val[0] = 32'h0101_0101;
    b2b_val[1] = 32'hA5A5_5A5A;
    b2b_val[2] = 32'h1357_9BDF;
    b2b_val[3] = 32'hFEDC_BA98;

    repeat (3) @(negedge clk);
    check("rst_dout", dataout_mem, 32'd0);
    check("rst_done", {31'd0, mem_done}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_mmio", mmio_out, 32'd0);
    #1 rst = 1'b1;

    access("st10", 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access("ld10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    access("st20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    access("sb21", 1'b1, 1'b1, 32'h21, 32'hFFFF_FF11, 1'b0, 32'h0);
    access("sb23", 1'b1, 1'b1, 32'h23, 32'h0000_0022, 1'b0, 32'h0);
    access("ld20", 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h2200_1100);
    access("ld23", 1'b0, 1'b0, 32'h23, 32'h0, 1'b0, 32'h2200_1100);

    access("st04", 1'b1, 1'b0, 32'h04, 32'h1234_5678, 1'b0, 32'h0);
    access("st06", 1'b1, 1'b0, 32'h06, 32'hAAAA_5555, 1'b1, 32'h0);
    access("ld04", 1'b0, 1'b0, 32'h04, 32'h0, 1'b0, 32'h1234_5678);

    access("ld1000", 1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
    access("st1000", 1'b1, 1'b0, 32'h1010, 32'h7777_7777, 1'b1, 32'h0);
    access("ld10_after_range", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) begin
      access("st_b2b", 1'b1, 1'b0, 32'h40 + 32'(4 * i), b2b_val[i], 1'b0, 32'h0);
    end

    // req held high: captures happen on every RESP edge.
    for (int i = 0; i < 4; i++) begin
      e.dat = b2b_val[i];
      e.err = 1'b0;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b1; wr_mem = 1'b0; store_sel = 1'b0; addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) addr = 32'h40 + 32'(4 * (i + 1));
      else req = 1'b0;
      @(negedge clk);
      check("b2b_gap", {31'd0, mem_done}, 32'd0);
      @(negedge clk);
      check("b2b_done", {31'd0, mem_done}, 32'd1);
      e = sb_q.pop_front();
      check("b2b_data", dataout_mem, e.dat);
      check("b2b_err", {31'd0, mem_err}, {31'd0, e.err});
    end
    last_dat = b2b_val[3];
    @(negedge clk);
    check("b2b_tail", {31'd0, mem_done}, 32'd0);

    // Reset while a store sits in ACCESS: dropped, no done, no write.
    @(posedge clk); #1;
    req = 1'b1; wr_mem = 1'b1; store_sel = 1'b0; addr = 32'h44; datain_mem = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_done", {31'd0, mem_done}, 32'd0);
      check("rst_mid_dout", dataout_mem, 32'd0);
      check("rst_mid_err", {31'd0, mem_err}, 32'd0);
    end
    #1 rst = 1'b1;
    last_dat = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_idle_done", {31'd0, mem_done}, 32'd0);
    end
    access("ld44_after_rst", 1'b0, 1'b0, 32'h44, 32'h0, 1'b0, b2b_val[1]);

`ifdef DMEM_MMIO_EN
    mmio_exp_err = 1'b0;
    mmio_exp_out = 32'h0000_00A5;
`else
    mmio_exp_err = 1'b1;
    mmio_exp_out = 32'h0;
`endif
    access("st_mmio", 1'b1, 1'b0, MMIO_ADDR, 32'h0000_00A5, mmio_exp_err, 32'h0);
    check("mmio_out", mmio_out, mmio_exp_out);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
